// File: rtl/prf_regfile_if.sv
// prf_regfile_if: read, write-back, allocation and flush bundle for the physical register file.
interface prf_regfile_if #(
    parameter int XLEN      = 32,
    parameter int NUM_PREGS = 64,
    parameter int NUM_RD    = 4,
    parameter int NUM_WR    = 2,
    parameter int NUM_ALLOC = 1
);
    localparam int PREG_W = $clog2(NUM_PREGS);
    logic [NUM_RD-1:0][PREG_W-1:0]    rd_addr_i;
    logic [NUM_RD-1:0][XLEN-1:0]      rd_data_o;
    logic [NUM_RD-1:0]                rd_ready_o;
    logic [NUM_WR-1:0]                wr_en_i;
    logic [NUM_WR-1:0][PREG_W-1:0]    wr_addr_i;
    logic [NUM_WR-1:0][XLEN-1:0]      wr_data_i;
    logic [NUM_ALLOC-1:0]             alloc_en_i;
    logic [NUM_ALLOC-1:0][PREG_W-1:0] alloc_addr_i;
    logic                             flush_i;
    logic                             wr_conflict_o;
    modport master (
        output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, alloc_en_i, alloc_addr_i, flush_i,
        input  rd_data_o, rd_ready_o, wr_conflict_o
    );
    modport slave (
        input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, alloc_en_i, alloc_addr_i, flush_i,
        output rd_data_o, rd_ready_o, wr_conflict_o
    );
endinterface

// File: rtl/prf_regfile.sv
// prf_regfile: physical register file with ready scoreboard, write-back bypass and p0 hardwired to zero.
module prf_regfile #(
    parameter int XLEN      = 32,
    parameter int NUM_PREGS = 64,
    parameter int NUM_RD    = 4,
    parameter int NUM_WR    = 2,
    parameter int NUM_ALLOC = 1
) (
    input logic        clk_i,
    input logic        rst_ni,
    prf_regfile_if.slave bus
);
    localparam int PREG_W = $clog2(NUM_PREGS);
    logic [XLEN-1:0]      data_q [NUM_PREGS];
    logic [XLEN-1:0]      data_d [NUM_PREGS];
    logic [NUM_PREGS-1:0] ready_q, ready_d;
    logic                 conflict_q, conflict_d;
    // Writes first, then alloc (alloc beats write on ready), then flush beats alloc.
    always_comb begin
        data_d     = data_q;
        ready_d    = ready_q;
        conflict_d = 1'b0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (bus.wr_en_i[w] && bus.wr_addr_i[w] != '0) begin
                data_d[bus.wr_addr_i[w]]  = bus.wr_data_i[w];
                ready_d[bus.wr_addr_i[w]] = 1'b1;
            end
            for (int v = w + 1; v < NUM_WR; v++)
                if (bus.wr_en_i[w] && bus.wr_en_i[v] && bus.wr_addr_i[w] == bus.wr_addr_i[v] && bus.wr_addr_i[w] != '0)
                    conflict_d = 1'b1;
        end
        for (int a = 0; a < NUM_ALLOC; a++)
            if (bus.alloc_en_i[a] && bus.alloc_addr_i[a] != '0)
                ready_d[bus.alloc_addr_i[a]] = 1'b0;
        if (bus.flush_i)
            ready_d = '1;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q     <= '{default: '0};
            ready_q    <= '1;
            conflict_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            ready_q    <= ready_d;
            conflict_q <= conflict_d;
        end
    end
    // Bypass is suppressed while in reset so reads show the reset state immediately.
    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            bus.rd_data_o[r]  = data_q[bus.rd_addr_i[r]];
            bus.rd_ready_o[r] = ready_q[bus.rd_addr_i[r]];
            for (int w = 0; w < NUM_WR; w++)
                if (rst_ni && bus.wr_en_i[w] && bus.wr_addr_i[w] != '0 && bus.wr_addr_i[w] == bus.rd_addr_i[r]) begin
                    bus.rd_data_o[r]  = bus.wr_data_i[w];
                    bus.rd_ready_o[r] = 1'b1;
                end
        end
    end
    assign bus.wr_conflict_o = conflict_q;
endmodule

// File: tb/tb_prf_regfile.sv
// tb_prf_regfile: directed vector table, reset corners and randomized traffic against a reference model.
module tb_prf_regfile;
    localparam int XLEN = 32, NP = 64, NRD = 4, NWR = 2, NAL = 1, PW = 6;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   checks = 0, failures = 0;
    always #5 clk_i = ~clk_i;
    prf_regfile_if #(.XLEN(XLEN), .NUM_PREGS(NP), .NUM_RD(NRD), .NUM_WR(NWR), .NUM_ALLOC(NAL)) bus ();
    prf_regfile #(.XLEN(XLEN), .NUM_PREGS(NP), .NUM_RD(NRD), .NUM_WR(NWR), .NUM_ALLOC(NAL)) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .bus(bus)
    );
    logic [XLEN-1:0] m_data [NP];
    logic            m_rdy  [NP];
    logic            m_conf;
    typedef struct {
        logic [1:0]  we;
        logic [5:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        ae;
        logic [5:0]  aa;
        logic        fl;
        logic [5:0]  ra3;
        logic [31:0] ed;
        logic        er;
        logic        ec;
    } vec_t;
    vec_t tbl [20];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask
    task automatic m_reset();
        for (int i = 0; i < NP; i++) begin
            m_data[i] = '0;
            m_rdy[i]  = 1'b1;
        end
        m_conf = 1'b0;
    endtask
    task automatic m_update();
        int cnt [NP];
        if (!rst_ni) begin
            m_reset();
            return;
        end
        for (int i = 0; i < NP; i++) cnt[i] = 0;
        for (int w = 0; w < NWR; w++)
            if (bus.wr_en_i[w] && bus.wr_addr_i[w] != 0) begin
                m_data[bus.wr_addr_i[w]] = bus.wr_data_i[w];
                m_rdy[bus.wr_addr_i[w]]  = 1'b1;
                cnt[bus.wr_addr_i[w]]++;
            end
        for (int a = 0; a < NAL; a++)
            if (bus.alloc_en_i[a] && bus.alloc_addr_i[a] != 0) m_rdy[bus.alloc_addr_i[a]] = 1'b0;
        if (bus.flush_i)
            for (int i = 0; i < NP; i++) m_rdy[i] = 1'b1;
        m_conf = 1'b0;
        for (int i = 1; i < NP; i++) if (cnt[i] > 1) m_conf = 1'b1;
    endtask
    task automatic check_model();
        logic [XLEN-1:0] ed;
        logic            er;
        int              a;
        for (int r = 0; r < NRD; r++) begin
            a  = int'(bus.rd_addr_i[r]);
            ed = m_data[a];
            er = m_rdy[a];
            if (rst_ni && a != 0)
                for (int w = 0; w < NWR; w++)
                    if (bus.wr_en_i[w] && int'(bus.wr_addr_i[w]) == a) begin
                        ed = bus.wr_data_i[w];
                        er = 1'b1;
                    end
            chk($sformatf("rd_data[%0d]@p%0d", r, a), bus.rd_data_o[r], ed);
            chk($sformatf("rd_ready[%0d]@p%0d", r, a), {31'b0, bus.rd_ready_o[r]}, {31'b0, er});
        end
        chk("wr_conflict", {31'b0, bus.wr_conflict_o}, {31'b0, m_conf});
    endtask
    task automatic cycle();
        @(negedge clk_i);
        check_model();
        m_update();
        @(posedge clk_i);
        #1;
    endtask
    task automatic idle();
        bus.wr_en_i    = '0;
        bus.alloc_en_i = '0;
        bus.flush_i    = 1'b0;
    endtask
    task automatic randomize_inputs(input bit narrow);
        for (int w = 0; w < NWR; w++) begin
            bus.wr_en_i[w]   = 1'($urandom);
            bus.wr_addr_i[w] = narrow ? PW'($urandom_range(0, 7)) : PW'($urandom);
            bus.wr_data_i[w] = $urandom;
        end
        bus.alloc_en_i[0]   = 1'($urandom);
        bus.alloc_addr_i[0] = narrow ? PW'($urandom_range(0, 7)) : PW'($urandom);
        bus.flush_i         = ($urandom_range(0, 15) == 0);
        for (int r = 0; r < NRD; r++)
            bus.rd_addr_i[r] = narrow ? PW'($urandom_range(0, 7)) : PW'($urandom);
    endtask
    initial begin
        tbl[0]  = '{2'b10, 6'd0,  6'd17, 32'h0,    32'hDEADBEEF, 1'b0, 6'd0,  1'b0, 6'd17, 32'hDEADBEEF, 1'b1, 1'b0};
        tbl[1]  = '{2'b00, 6'd0,  6'd0,  32'h0,    32'h0,        1'b0, 6'd0,  1'b0, 6'd17, 32'hDEADBEEF, 1'b1, 1'b0};
        tbl[2]  = '{2'b11, 6'd0,  6'd0,  32'h1234, 32'h1234,     1'b1, 6'd0,  1'b0, 6'd0,  32'h0,        1'b1, 1'b0};
        tbl[3]  = '{2'b00, 6'd0,  6'd0,  32'h0,    32'h0,        1'b0, 6'd0,  1'b0, 6'd0,  32'h0,        1'b1, 1'b0};
        tbl[4]  = '{2'b00, 6'd0,  6'd0,  32'h0,    32'h0,        1'b1, 6'd5,  1'b0, 6'd5,  32'h0,        1'b1, 1'b0};
        tbl[5]  = '{2'b00, 6'd0,  6'd0,  32'h0,    32'h0,        1'b0, 6'd0,  1'b0, 6'd5,  32'h0,        1'b0, 1'b0};
        tbl[6]  = '{2'b01, 6'd5,  6'd0,  32'h7,    32'h0,        1'b0, 6'd0,  1'b0, 6'd5,  32'h7,        1'b1, 1'b0};
        tbl[7]  = '{2'b10, 6'd0,  6'd9,  32'h0,    32'h99,       1'b1, 6'd9,  1'b0, 6'd9,  32'h99,       1'b1, 1'b0};
        tbl[8]  = '{2'b00, 6'd0,  6'd0,  32'h0,    32'h0,        1'b0, 6'd0,  1'b0, 6'd9,  32'h99,       1'b0, 1'b0};
        tbl[9]  = '{2'b11, 6'd12, 6'd12, 32'hA,    32'hB,        1'b0, 6'd0,  1'b0, 6'd12, 32'hB,        1'b1, 1'b0};
        tbl[10] = '{2'b00, 6'd0,  6'd0,  32'h0,    32'h0,        1'b0, 6'd0,  1'b0, 6'd12, 32'hB,        1'b1, 1'b1};
        tbl[11] = '{2'b00, 6'd0,  6'd0,  32'h0,    32'h0,        1'b0, 6'd0,  1'b0, 6'd12, 32'hB,        1'b1, 1'b0};
        tbl[12] = '{2'b00, 6'd0,  6'd0,  32'h0,    32'h0,        1'b1, 6'd3,  1'b0, 6'd3,  32'h0,        1'b1, 1'b0};
        tbl[13] = '{2'b00, 6'd0,  6'd0,  32'h0,    32'h0,        1'b1, 6'd4,  1'b0, 6'd3,  32'h0,        1'b0, 1'b0};
        tbl[14] = '{2'b00, 6'd0,  6'd0,  32'h0,    32'h0,        1'b1, 6'd60, 1'b0, 6'd4,  32'h0,        1'b0, 1'b0};
        tbl[15] = '{2'b00, 6'd0,  6'd0,  32'h0,    32'h0,        1'b1, 6'd8,  1'b1, 6'd60, 32'h0,        1'b0, 1'b0};
        tbl[16] = '{2'b00, 6'd0,  6'd0,  32'h0,    32'h0,        1'b0, 6'd0,  1'b0, 6'd60, 32'h0,        1'b1, 1'b0};
        tbl[17] = '{2'b00, 6'd0,  6'd0,  32'h0,    32'h0,        1'b0, 6'd0,  1'b0, 6'd8,  32'h0,        1'b1, 1'b0};
        tbl[18] = '{2'b00, 6'd0,  6'd0,  32'h0,    32'h0,        1'b0, 6'd0,  1'b0, 6'd3,  32'h0,        1'b1, 1'b0};
        tbl[19] = '{2'b00, 6'd0,  6'd0,  32'h0,    32'h0,        1'b0, 6'd0,  1'b0, 6'd4,  32'h0,        1'b1, 1'b0};
        m_reset();
        randomize_inputs(1'b0);
        for (int i = 0; i < 4; i++) begin
            randomize_inputs(i[0]);
            cycle();
        end
        idle();
        for (int a = 0; a < NP; a += NRD) begin
            for (int r = 0; r < NRD; r++) bus.rd_addr_i[r] = PW'(a + r);
            #1;
            check_model();
        end
        rst_ni = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.wr_en_i         = tbl[i].we;
            bus.wr_addr_i[0]    = tbl[i].wa0;
            bus.wr_addr_i[1]    = tbl[i].wa1;
            bus.wr_data_i[0]    = tbl[i].wd0;
            bus.wr_data_i[1]    = tbl[i].wd1;
            bus.alloc_en_i[0]   = tbl[i].ae;
            bus.alloc_addr_i[0] = tbl[i].aa;
            bus.flush_i         = tbl[i].fl;
            for (int r = 0; r < NRD - 1; r++) bus.rd_addr_i[r] = PW'($urandom);
            bus.rd_addr_i[3] = tbl[i].ra3;
            @(negedge clk_i);
            chk($sformatf("vec%0d rd_data3", i), bus.rd_data_o[3], tbl[i].ed);
            chk($sformatf("vec%0d rd_ready3", i), {31'b0, bus.rd_ready_o[3]}, {31'b0, tbl[i].er});
            chk($sformatf("vec%0d conflict", i), {31'b0, bus.wr_conflict_o}, {31'b0, tbl[i].ec});
            check_model();
            m_update();
            @(posedge clk_i);
            #1;
        end
        for (int i = 0; i < 400; i++) begin
            randomize_inputs(i < 200);
            cycle();
        end
        idle();
        bus.wr_en_i = 2'b11;
        bus.wr_addr_i[0] = 6'd20;
        bus.wr_addr_i[1] = 6'd20;
        bus.wr_data_i[0] = 32'h11;
        bus.wr_data_i[1] = 32'h55;
        bus.rd_addr_i[0] = 6'd20;
        cycle();
        bus.wr_en_i = 2'b01;
        bus.wr_addr_i[0] = 6'd21;
        bus.alloc_en_i = 1'b1;
        bus.alloc_addr_i[0] = 6'd20;
        bus.rd_addr_i[1] = 6'd21;
        #1;
        chk("pre_reset p20", bus.rd_data_o[0], 32'h55);
        chk("pre_reset conflict", {31'b0, bus.wr_conflict_o}, 32'h1);
        rst_ni = 1'b0;
        m_reset();
        #1;
        chk("midreset p20 data", bus.rd_data_o[0], 32'h0);
        chk("midreset p20 ready", {31'b0, bus.rd_ready_o[0]}, 32'h1);
        chk("midreset p21 bypass", bus.rd_data_o[1], 32'h0);
        chk("midreset conflict", {31'b0, bus.wr_conflict_o}, 32'h0);
        check_model();
        cycle();
        rst_ni = 1'b1;
        idle();
        for (int i = 0; i < 100; i++) begin
            randomize_inputs(1'b1);
            cycle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
